div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The module SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The module SHALL have port resetn, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-004 The module SHALL have port start, input, 1, request a division (sampled only in IDLE).
REQ-005 The module SHALL have port sign, input, 1, 1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 The module SHALL have port a, input, WIDTH, dividend; sampled with start.
REQ-007 The module SHALL have port b, input, WIDTH, divisor; sampled with start.
REQ-008 The module SHALL have port cancel, input, 1, pipeline flush; aborts the operation in flight.
REQ-009 The module SHALL have port busy, output, 1, high while iterating (stall request to the pipeline).
REQ-010 The module SHALL have port valid, output, 1, one-cycle pulse marking hi/lo as fresh.
REQ-011 The module SHALL have port lo, output, WIDTH, quotient (registered).
REQ-012 The module SHALL have port hi, output, WIDTH, remainder (registered).

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-014 IDLE: start=1 and cancel=0 SHALL latch a, b, sign; b != 0 -> BUSY, iteration counter = 0; b == 0 -> DONE.
REQ-015 BUSY SHALL perform one restoring shift-subtract step per cycle on magnitudes, exactly WIDTH steps, then -> DONE.
REQ-016 DONE SHALL last exactly one cycle with valid=1, then -> IDLE.
REQ-017 busy SHALL be 1 in BUSY only; valid SHALL be 1 in DONE only.
REQ-018 Latency: start sampled at edge E0 with b != 0 -> valid high in the cycle after edge E0+WIDTH (WIDTH+1 cycles for WIDTH=32: 33); b == 0 -> valid in the cycle after E0.
REQ-019 hi/lo SHALL update on the edge entering DONE and hold until the next entry to DONE.
REQ-020 Signed mode: |a|, |b| used; quotient negated when sign(a) != sign(b); remainder takes the sign of a; magnitude arithmetic SHALL be WIDTH+1 bits wide so that -2^(WIDTH-1) is handled.
REQ-021 Signed overflow (a = 0x80000000, b = 0xFFFFFFFF) SHALL give lo = 0x80000000, hi = 0.
REQ-022 Divide by zero (either mode) SHALL give lo = all ones, hi = a.
REQ-023 start in BUSY or DONE SHALL be ignored; operands SHALL NOT be re-latched.
REQ-024 cancel=1 in BUSY or DONE SHALL force IDLE on the next edge; valid SHALL be 0 in that cycle, and hi/lo SHALL keep their previous values.
REQ-025 start=1 with cancel=1 in IDLE: cancel SHALL win; no operation starts.
REQ-026 Operand inputs SHALL be allowed to change while busy without affecting the result.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, counter 0, busy=0, valid=0, hi=0, lo=0, and clear operand/partial registers.
REQ-028 Reset deasserted mid-operation SHALL leave the block in IDLE; the aborted division SHALL NOT produce valid.

Verification
REQ-029 Unsigned: a=100, b=7, sign=0 -> busy high 32 cycles, then valid pulse with lo=14, hi=2.
REQ-030 Signed: a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); a=7, b=-2 -> lo=-3, hi=1.
REQ-031 Boundaries: signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; unsigned 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0.
REQ-032 Divide by zero: a=0x1234, b=0 -> valid in the cycle after start, lo=0xFFFFFFFF, hi=0x1234, busy never high.
REQ-033 Cancel at iteration 10 -> IDLE next cycle, no valid, hi/lo unchanged; a new start then completes normally; start pulses during BUSY are ignored.
REQ-034 resetn pulled low at iteration 20 -> busy=0, valid=0, hi=lo=0 asynchronously; no valid follows the release.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring divider: one shift-subtract step per cycle on operand magnitudes.
// Handles signed and unsigned modes, divide-by-zero, flush via cancel.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   div_q, div_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    // One extra bit so the magnitude of the most negative value is representable.
    logic [WIDTH:0]   a_ext, b_ext, abs_a, abs_b;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx, lo_fin, hi_fin;

    always_comb begin
        a_ext  = {sign & a[WIDTH-1], a};
        b_ext  = {sign & b[WIDTH-1], b};
        abs_a  = a_ext[WIDTH] ? (~a_ext + 1'b1) : a_ext;
        abs_b  = b_ext[WIDTH] ? (~b_ext + 1'b1) : b_ext;
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        ge     = (rem_sh >= div_q);
        rem_nx = ge ? WIDTH'(rem_sh - div_q) : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], ge};
        lo_fin = negq_q ? (~quo_nx + 1'b1) : quo_nx;
        hi_fin = negr_q ? (~rem_nx + 1'b1) : rem_nx;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            StIdle: begin
                if (start && !cancel) begin
                    negq_d = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                    negr_d = sign & a[WIDTH-1];
                    rem_d  = '0;
                    quo_d  = WIDTH'(abs_a);
                    div_d  = abs_b;
                    cnt_d  = '0;
                    if (b == '0) begin
                        state_d = StDone;
                        lo_d    = '1;
                        hi_d    = a;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = StDone;
                        lo_d    = lo_fin;
                        hi_d    = hi_fin;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign busy  = (state_q == StBusy);
    assign valid = (state_q == StDone);
    assign lo    = lo_q;
    assign hi    = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: reference results queued at issue, compared on each valid.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start, sign, cancel;
    logic [W-1:0] a, b;
    logic         busy, valid;
    logic [W-1:0] lo, hi;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0]  sb_q[$];
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .valid  (valid),
        .lo     (lo),
        .hi     (hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient} with truncating division semantics.
    function automatic logic [63:0] model(input logic s, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        longint sx, sy, q, r;
        if (y == '0) return {x, 32'hFFFF_FFFF};
        if (!s) return {x % y, x / y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 64'(valid), 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("lo", 64'(lo), 64'(e[31:0]));
                check("hi", 64'(hi), 64'(e[63:32]));
                last_lo = e[31:0];
                last_hi = e[63:32];
            end
        end
    end

    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        sign  = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sign  = 1'($urandom);
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke_start);
        int n, busy_n;
        bit got;
        sb_q.push_back(model(s, x, y));
        issue(s, x, y);
        n = 0;
        busy_n = 0;
        got = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (valid) got = 1;
            if (poke_start && n == 5) begin
                start = 1'b1;
                a     = '0;
                b     = '0;
            end
            if (n == 6) start = 1'b0;
        end
        check("valid_seen", 64'(got), 64'd1);
        check("latency", 64'(n), (y == '0) ? 64'd1 : 64'(W + 1));
        check("busy_cycles", 64'(busy_n), (y == '0) ? 64'd0 : 64'(W));
        @(negedge clk);
        check("valid_one_cycle", 64'(valid), 64'd0);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        sign   = 1'b0;
        cancel = 1'b0;
        a      = '0;
        b      = '0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, 1'b1);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 32'h1234, 32'd0, 1'b0);
        run_op(1'b1, 32'hFFFF_0000, 32'd0, 1'b0);

        // Flush at iteration 10: no result, outputs hold.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        check("busy_before_cancel", 64'(busy), 64'd1);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_valid", 64'(valid), 64'd0);
        check("cancel_lo_hold", 64'(lo), 64'(last_lo));
        check("cancel_hi_hold", 64'(hi), 64'(last_hi));
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd1000, 32'd3, 1'b0);

        // start with cancel in idle must not launch.
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        b      = 32'd5;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        check("start_cancel_busy", 64'(busy), 64'd0);
        check("start_cancel_valid", 64'(valid), 64'd0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = (i == 3) ? 32'd0 : ((i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom));
            run_op(1'(i % 2), x, y, 1'b0);
        end

        // Asynchronous reset at iteration 20.
        issue(1'b1, 32'hDEAD_BEEF, 32'd13);
        repeat (20) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(valid), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        last_lo = '0;
        last_hi = '0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_after_reset", 64'(busy), 64'd0);

        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
        check("queue_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
